// File: rtl/cp0.sv
// CP0 system coprocessor: BadVAddr, Count, Compare, Status, Cause and EPC,
// exception/ERET commit from the WB stage, fetch redirect and the timer interrupt.
module cp0 #(
  parameter logic [31:0] EXC_ENTRY = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mtc0,
  input  logic        mfc0,
  input  logic [7:0]  cp0r_addr,
  input  logic [31:0] wdata,
  input  logic        syscall,
  input  logic        eret,
  input  logic [31:0] pc,
  input  logic        wb_valid,
  input  logic        wb_over,
  input  logic        ex_valid_i,
  input  logic [4:0]  ex_code_i,
  input  logic        ex_bd_i,
  input  logic [31:0] ex_pc_i,
  input  logic        badvaddr_valid_i,
  input  logic [31:0] badvaddr_i,
  output logic [31:0] cp0r_rdata,
  output logic        cancel,
  output logic        exc_valid,
  output logic [31:0] exc_pc,
  output logic [31:0] cp0r_status,
  output logic [31:0] cp0r_cause,
  output logic [31:0] cp0r_epc,
  output logic        c0_int
);

  localparam logic [7:0] ADDR_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] ADDR_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] ADDR_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] ADDR_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] ADDR_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] ADDR_EPC      = {5'd14, 3'd0};

  logic [31:0] r_badvaddr;
  logic [31:0] r_count;
  logic        r_tick;
  logic [31:0] r_compare;
  logic        r_cmp_written;
  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic        r_ti;
  logic [1:0]  r_ip_sw;
  logic [4:0]  r_exc_code;
  logic [31:0] r_epc;

  logic        w_commit;
  logic        w_exc;
  logic        w_eret;
  logic        w_wr;
  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic        w_unused;

  // mfc0/syscall/pc carry no behaviour here: reads are always driven and
  // syscall arrives already folded into ex_valid_i.
  assign w_unused = ^{mfc0, syscall, pc};

  assign w_commit = wb_over & wb_valid;
  assign w_exc    = ex_valid_i & w_commit;
  assign w_eret   = eret & w_commit & ~ex_valid_i;
  assign w_wr     = mtc0 & w_commit & ~ex_valid_i;

  assign w_status = {9'b0, 1'b1, 6'b0, r_im, 6'b0, r_exl, r_ie};
  assign w_cause  = {r_bd, r_ti, 14'b0, r_ti, 5'b0, r_ip_sw, 1'b0, r_exc_code, 2'b0};

  assign cp0r_status = w_status;
  assign cp0r_cause  = w_cause;
  assign cp0r_epc    = r_epc;

  assign exc_valid = (ex_valid_i | eret) & w_commit;
  assign cancel    = exc_valid;
  assign exc_pc    = ex_valid_i ? EXC_ENTRY : r_epc;
  assign c0_int    = r_ie & ~r_exl & (|(w_cause[15:8] & r_im));

  // Read mux reflects the pre-write register values.
  always_comb begin
    cp0r_rdata = 32'h0;
    case (cp0r_addr)
      ADDR_BADVADDR: cp0r_rdata = r_badvaddr;
      ADDR_COUNT:    cp0r_rdata = r_count;
      ADDR_COMPARE:  cp0r_rdata = r_compare;
      ADDR_STATUS:   cp0r_rdata = w_status;
      ADDR_CAUSE:    cp0r_rdata = w_cause;
      ADDR_EPC:      cp0r_rdata = r_epc;
      default:       cp0r_rdata = 32'h0;
    endcase
  end

  // Count advances on every other clock; a software write replaces that cycle's increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick  <= 1'b0;
      r_count <= 32'h0;
    end else begin
      r_tick <= ~r_tick;
      if (w_wr && cp0r_addr == ADDR_COUNT)
        r_count <= wdata;
      else if (r_tick)
        r_count <= r_count + 32'd1;
    end
  end

  // Compare register and timer interrupt; a Compare write clears TI ahead of any match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_compare     <= 32'h0;
      r_cmp_written <= 1'b0;
      r_ti          <= 1'b0;
    end else if (w_wr && cp0r_addr == ADDR_COMPARE) begin
      r_compare     <= wdata;
      r_cmp_written <= 1'b1;
      r_ti          <= 1'b0;
    end else if (r_cmp_written && r_count == r_compare) begin
      r_ti <= 1'b1;
    end
  end

  // Status: exception entry sets EXL, ERET clears it, otherwise MTC0 updates the writable fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_im  <= 8'h0;
      r_exl <= 1'b0;
      r_ie  <= 1'b0;
    end else if (w_exc) begin
      r_exl <= 1'b1;
    end else if (w_eret) begin
      r_exl <= 1'b0;
    end else if (w_wr && cp0r_addr == ADDR_STATUS) begin
      r_im  <= wdata[15:8];
      r_exl <= wdata[1];
      r_ie  <= wdata[0];
    end
  end

  // Cause: ExcCode/BD from exception entry (BD frozen while nested), software IP from MTC0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bd       <= 1'b0;
      r_ip_sw    <= 2'b0;
      r_exc_code <= 5'h0;
    end else if (w_exc) begin
      r_exc_code <= ex_code_i;
      if (!r_exl)
        r_bd <= ex_bd_i;
    end else if (w_wr && cp0r_addr == ADDR_CAUSE) begin
      r_ip_sw <= wdata[9:8];
    end
  end

  // EPC captures the restart PC only on a non-nested exception; BadVAddr on address faults.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_epc      <= 32'h0;
      r_badvaddr <= 32'h0;
    end else begin
      if (w_exc) begin
        if (!r_exl)
          r_epc <= ex_bd_i ? (ex_pc_i - 32'd4) : ex_pc_i;
      end else if (w_wr && cp0r_addr == ADDR_EPC) begin
        r_epc <= wdata;
      end
      if (w_exc && badvaddr_valid_i)
        r_badvaddr <= badvaddr_i;
    end
  end

endmodule

// File: tb/tb_cp0.sv
// Directed bench for cp0: a vector table for commit/exception/ERET/MTC0
// behaviour, plus sequences for the timer, Count wrap and async reset.
module tb_cp0;

  localparam logic [7:0] ST = 8'h60;
  localparam logic [7:0] CA = 8'h68;
  localparam logic [7:0] EP = 8'h70;
  localparam logic [7:0] BV = 8'h40;
  localparam logic [7:0] CN = 8'h48;
  localparam logic [7:0] CM = 8'h58;
  localparam logic [7:0] NA = 8'hA0;

  logic        clk = 1'b0;
  logic        reset;
  logic        mtc0, mfc0, syscall, eret, wb_valid, wb_over;
  logic        ex_valid_i, ex_bd_i, badvaddr_valid_i;
  logic [7:0]  cp0r_addr;
  logic [31:0] wdata, pc, ex_pc_i, badvaddr_i;
  logic [4:0]  ex_code_i;
  logic [31:0] cp0r_rdata, exc_pc, cp0r_status, cp0r_cause, cp0r_epc;
  logic        cancel, exc_valid, c0_int;

  int n_chk = 0;
  int n_err = 0;

  cp0 dut (
    .clk(clk), .reset(reset), .mtc0(mtc0), .mfc0(mfc0), .cp0r_addr(cp0r_addr),
    .wdata(wdata), .syscall(syscall), .eret(eret), .pc(pc), .wb_valid(wb_valid),
    .wb_over(wb_over), .ex_valid_i(ex_valid_i), .ex_code_i(ex_code_i),
    .ex_bd_i(ex_bd_i), .ex_pc_i(ex_pc_i), .badvaddr_valid_i(badvaddr_valid_i),
    .badvaddr_i(badvaddr_i), .cp0r_rdata(cp0r_rdata), .cancel(cancel),
    .exc_valid(exc_valid), .exc_pc(exc_pc), .cp0r_status(cp0r_status),
    .cp0r_cause(cp0r_cause), .cp0r_epc(cp0r_epc), .c0_int(c0_int)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mtc0;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        eret;
    logic        wbv;
    logic        wbo;
    logic        exv;
    logic [4:0]  code;
    logic        bd;
    logic [31:0] xpc;
    logic        bvv;
    logic [31:0] bva;
    logic [31:0] e_rdata;
    logic        e_excv;
    logic [31:0] e_excpc;
    logic [31:0] e_status;
    logic [31:0] e_cause;
    logic [31:0] e_epc;
    logic        e_int;
  } vec_t;

  vec_t tbl[28];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    mtc0 = 0; mfc0 = 0; syscall = 0; eret = 0; wb_valid = 0; wb_over = 0;
    ex_valid_i = 0; ex_code_i = 0; ex_bd_i = 0; ex_pc_i = 0;
    badvaddr_valid_i = 0; badvaddr_i = 0; cp0r_addr = 0; wdata = 0; pc = 0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    idle();
    mtc0 = 1; wb_valid = 1; wb_over = 1; cp0r_addr = a; wdata = d;
    @(negedge clk);
    idle();
  endtask

  initial begin
    bit found;

    //          mtc0 addr  wdata          eret wbv wbo exv code   bd xpc            bvv bva            | rdata          excv excpc          status         cause          epc            int
    tbl[0]  = '{0, ST, 32'h0,          0, 0, 0, 0, 5'd0,  0, 32'h0,    0, 32'h0,          32'h0040_0000, 0, 32'h0,         32'h0040_0000, 32'h0,         32'h0,    0};
    tbl[1]  = '{0, ST, 32'h0,          0, 1, 1, 1, 5'd8,  0, 32'h1000, 0, 32'h0,          32'h0040_0000, 1, 32'hBFC0_0380, 32'h0040_0000, 32'h0,         32'h0,    0};
    tbl[2]  = '{0, EP, 32'h0,          0, 0, 0, 0, 5'd0,  0, 32'h0,    0, 32'h0,          32'h0000_1000, 0, 32'h1000,      32'h0040_0002, 32'h20,        32'h1000, 0};
    tbl[3]  = '{0, ST, 32'h0,          1, 1, 1, 0, 5'd0,  0, 32'h0,    0, 32'h0,          32'h0040_0002, 1, 32'h1000,      32'h0040_0002, 32'h20,        32'h1000, 0};
    tbl[4]  = '{0, ST, 32'h0,          0, 0, 0, 0, 5'd0,  0, 32'h0,    0, 32'h0,          32'h0040_0000, 0, 32'h1000,      32'h0040_0000, 32'h20,        32'h1000, 0};
    tbl[5]  = '{0, BV, 32'h0,          0, 1, 1, 1, 5'd4,  1, 32'h2004, 1, 32'h8000_0003,  32'h0,         1, 32'hBFC0_0380, 32'h0040_0000, 32'h20,        32'h1000, 0};
    tbl[6]  = '{0, BV, 32'h0,          0, 0, 0, 0, 5'd0,  0, 32'h0,    0, 32'h0,          32'h8000_0003, 0, 32'h2000,      32'h0040_0002, 32'h8000_0010, 32'h2000, 0};
    tbl[7]  = '{0, BV, 32'h0,          0, 1, 1, 1, 5'd8,  0, 32'h3000, 0, 32'h0,          32'h8000_0003, 1, 32'hBFC0_0380, 32'h0040_0002, 32'h8000_0010, 32'h2000, 0};
    tbl[8]  = '{0, CA, 32'h0,          0, 0, 0, 0, 5'd0,  0, 32'h0,    0, 32'h0,          32'h8000_0020, 0, 32'h2000,      32'h0040_0002, 32'h8000_0020, 32'h2000, 0};
    tbl[9]  = '{1, EP, 32'h1234,       0, 1, 0, 0, 5'd0,  0, 32'h0,    0, 32'h0,          32'h2000,      0, 32'h2000,      32'h0040_0002, 32'h8000_0020, 32'h2000, 0};
    tbl[10] = '{0, EP, 32'h0,          0, 0, 0, 0, 5'd0,  0, 32'h0,    0, 32'h0,          32'h2000,      0, 32'h2000,      32'h0040_0002, 32'h8000_0020, 32'h2000, 0};
    tbl[11] = '{0, NA, 32'h0,          0, 0, 0, 0, 5'd0,  0, 32'h0,    0, 32'h0,          32'h0,         0, 32'h2000,      32'h0040_0002, 32'h8000_0020, 32'h2000, 0};
    tbl[12] = '{1, EP, 32'h1234,       0, 1, 1, 0, 5'd0,  0, 32'h0,    0, 32'h0,          32'h2000,      0, 32'h2000,      32'h0040_0002, 32'h8000_0020, 32'h2000, 0};
    tbl[13] = '{0, EP, 32'h0,          0, 0, 0, 0, 5'd0,  0, 32'h0,    0, 32'h0,          32'h1234,      0, 32'h1234,      32'h0040_0002, 32'h8000_0020, 32'h1234, 0};
    tbl[14] = '{1, ST, 32'h0,          0, 1, 1, 1, 5'd12, 0, 32'h4000, 0, 32'h0,          32'h0040_0002, 1, 32'hBFC0_0380, 32'h0040_0002, 32'h8000_0020, 32'h1234, 0};
    tbl[15] = '{0, ST, 32'h0,          0, 0, 0, 0, 5'd0,  0, 32'h0,    0, 32'h0,          32'h0040_0002, 0, 32'h1234,      32'h0040_0002, 32'h8000_0030, 32'h1234, 0};
    tbl[16] = '{0, ST, 32'h0,          1, 1, 0, 0, 5'd0,  0, 32'h0,    0, 32'h0,          32'h0040_0002, 0, 32'h1234,      32'h0040_0002, 32'h8000_0030, 32'h1234, 0};
    tbl[17] = '{0, ST, 32'h0,          1, 1, 1, 0, 5'd0,  0, 32'h0,    0, 32'h0,          32'h0040_0002, 1, 32'h1234,      32'h0040_0002, 32'h8000_0030, 32'h1234, 0};
    tbl[18] = '{1, CA, 32'hFFFF_FFFF,  0, 1, 1, 0, 5'd0,  0, 32'h0,    0, 32'h0,          32'h8000_0030, 0, 32'h1234,      32'h0040_0000, 32'h8000_0030, 32'h1234, 0};
    tbl[19] = '{0, CA, 32'h0,          0, 0, 0, 0, 5'd0,  0, 32'h0,    0, 32'h0,          32'h8000_0330, 0, 32'h1234,      32'h0040_0000, 32'h8000_0330, 32'h1234, 0};
    tbl[20] = '{1, ST, 32'h0000_0301,  0, 1, 1, 0, 5'd0,  0, 32'h0,    0, 32'h0,          32'h0040_0000, 0, 32'h1234,      32'h0040_0000, 32'h8000_0330, 32'h1234, 0};
    tbl[21] = '{0, ST, 32'h0,          0, 0, 0, 0, 5'd0,  0, 32'h0,    0, 32'h0,          32'h0040_0301, 0, 32'h1234,      32'h0040_0301, 32'h8000_0330, 32'h1234, 1};
    tbl[22] = '{1, CA, 32'h0,          0, 1, 1, 0, 5'd0,  0, 32'h0,    0, 32'h0,          32'h8000_0330, 0, 32'h1234,      32'h0040_0301, 32'h8000_0330, 32'h1234, 1};
    tbl[23] = '{0, CA, 32'h0,          0, 0, 0, 0, 5'd0,  0, 32'h0,    0, 32'h0,          32'h8000_0030, 0, 32'h1234,      32'h0040_0301, 32'h8000_0030, 32'h1234, 0};
    tbl[24] = '{1, ST, 32'hFFFF_FFFF,  0, 1, 1, 0, 5'd0,  0, 32'h0,    0, 32'h0,          32'h0040_0301, 0, 32'h1234,      32'h0040_0301, 32'h8000_0030, 32'h1234, 0};
    tbl[25] = '{0, ST, 32'h0,          0, 0, 0, 0, 5'd0,  0, 32'h0,    0, 32'h0,          32'h0040_FF03, 0, 32'h1234,      32'h0040_FF03, 32'h8000_0030, 32'h1234, 0};
    tbl[26] = '{1, ST, 32'h0,          0, 1, 1, 0, 5'd0,  0, 32'h0,    0, 32'h0,          32'h0040_FF03, 0, 32'h1234,      32'h0040_FF03, 32'h8000_0030, 32'h1234, 0};
    tbl[27] = '{0, ST, 32'h0,          0, 0, 0, 0, 5'd0,  0, 32'h0,    0, 32'h0,          32'h0040_0000, 0, 32'h1234,      32'h0040_0000, 32'h8000_0030, 32'h1234, 0};

    // Reset values, observed before any clock edge.
    idle();
    reset = 1;
    cp0r_addr = ST;
    #1;
    chk("rst_rdata_status", cp0r_rdata, 32'h0040_0000);
    chk("rst_status", cp0r_status, 32'h0040_0000);
    chk("rst_cause", cp0r_cause, 32'h0);
    chk("rst_epc", cp0r_epc, 32'h0);
    chk("rst_exc_pc", exc_pc, 32'h0);
    chk("rst_c0_int", {31'b0, c0_int}, 32'h0);
    chk("rst_exc_valid", {31'b0, exc_valid}, 32'h0);
    chk("rst_cancel", {31'b0, cancel}, 32'h0);
    cp0r_addr = CN;
    #1;
    chk("rst_rdata_count", cp0r_rdata, 32'h0);
    @(negedge clk);
    reset = 0;

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      mtc0 = tbl[i].mtc0; cp0r_addr = tbl[i].addr; wdata = tbl[i].wdata;
      eret = tbl[i].eret; wb_valid = tbl[i].wbv; wb_over = tbl[i].wbo;
      ex_valid_i = tbl[i].exv; ex_code_i = tbl[i].code; ex_bd_i = tbl[i].bd;
      ex_pc_i = tbl[i].xpc; badvaddr_valid_i = tbl[i].bvv; badvaddr_i = tbl[i].bva;
      syscall = tbl[i].exv && (tbl[i].code == 5'd8);
      #1;
      chk($sformatf("v%0d_rdata", i), cp0r_rdata, tbl[i].e_rdata);
      chk($sformatf("v%0d_exc_valid", i), {31'b0, exc_valid}, {31'b0, tbl[i].e_excv});
      chk($sformatf("v%0d_cancel", i), {31'b0, cancel}, {31'b0, tbl[i].e_excv});
      chk($sformatf("v%0d_exc_pc", i), exc_pc, tbl[i].e_excpc);
      chk($sformatf("v%0d_status", i), cp0r_status, tbl[i].e_status);
      chk($sformatf("v%0d_cause", i), cp0r_cause, tbl[i].e_cause);
      chk($sformatf("v%0d_epc", i), cp0r_epc, tbl[i].e_epc);
      chk($sformatf("v%0d_c0_int", i), {31'b0, c0_int}, {31'b0, tbl[i].e_int});
    end
    @(negedge clk);
    idle();

    // Timer interrupt: Count from 0, Compare 5, IM7 and IE enabled.
    wr(CN, 32'h0);
    wr(ST, 32'h0000_8001);
    wr(CM, 32'd5);
    #1;
    chk("ti_before_match", {31'b0, cp0r_cause[30]}, 32'h0);
    cp0r_addr = CM;
    #1;
    chk("compare_read", cp0r_rdata, 32'd5);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      #1;
      if (c0_int) found = 1;
    end
    chk("timer_int_wait", {31'b0, found}, 32'h1);
    chk("timer_cause_ti", {31'b0, cp0r_cause[30]}, 32'h1);
    chk("timer_cause_ip7", {31'b0, cp0r_cause[15]}, 32'h1);
    wr(CM, 32'd1000);
    #1;
    chk("ti_clear_int", {31'b0, c0_int}, 32'h0);
    chk("ti_clear_cause", {31'b0, cp0r_cause[30]}, 32'h0);
    repeat (4) @(negedge clk);
    #1;
    chk("ti_stays_clear", {31'b0, c0_int}, 32'h0);

    // Count write overrides the increment and wraps to zero.
    wr(CN, 32'hFFFF_FFFF);
    cp0r_addr = CN;
    #1;
    chk("count_write", cp0r_rdata, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    #1;
    chk("count_wrap", cp0r_rdata, 32'h0);
    repeat (4) @(negedge clk);
    #1;
    chk("count_half_rate", cp0r_rdata, 32'd2);

    // Async reset while EXL is set.
    @(negedge clk);
    idle();
    ex_valid_i = 1; wb_valid = 1; wb_over = 1; ex_code_i = 5'd8; ex_pc_i = 32'h5000;
    @(negedge clk);
    idle();
    #1;
    chk("pre_reset_exl", {31'b0, cp0r_status[1]}, 32'h1);
    chk("pre_reset_epc", cp0r_epc, 32'h5000);
    @(posedge clk);
    #2;
    reset = 1;
    cp0r_addr = ST;
    #1;
    chk("async_rst_status", cp0r_rdata, 32'h0040_0000);
    chk("async_rst_epc", cp0r_epc, 32'h0);
    chk("async_rst_exc_pc", exc_pc, 32'h0);
    chk("async_rst_int", {31'b0, c0_int}, 32'h0);
    cp0r_addr = EP;
    #1;
    chk("async_rst_rdata_epc", cp0r_rdata, 32'h0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 SHALL have parameter EXC_ENTRY, default 32'hBFC0_0380, the exception handler entry PC.
REQ-002 SHALL have one clock and an asynchronous, active-high reset.
REQ-003 SHALL have ports, one per line:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mtc0  in  1  MTC0 instruction in WB.
- mfc0  in  1  MFC0 instruction in WB; informational only, the read is always driven.
- cp0r_addr  in  8  {rd[4:0], sel[2:0]}.
- wdata  in  32  MTC0 write data.
- syscall  in  1  SYSCALL in WB; informational, already folded into ex_valid_i.
- eret  in  1  ERET in WB.
- pc  in  32  WB instruction PC.
- wb_valid  in  1  WB stage holds a valid instruction.
- wb_over  in  1  WB instruction commits this cycle.
- ex_valid_i  in  1  exception raised by the WB instruction.
- ex_code_i  in  5  ExcCode.
- ex_bd_i  in  1  instruction is in a delay slot.
- ex_pc_i  in  32  faulting instruction PC.
- badvaddr_valid_i  in  1  address-type exception; capture badvaddr_i.
- badvaddr_i  in  32  faulting virtual address.
- cp0r_rdata  out  32  combinational read of the addressed register.
- cancel  out  1  flush the younger pipeline stages.
- exc_valid  out  1  redirect fetch.
- exc_pc  out  32  redirect target.
- cp0r_status / cp0r_cause / cp0r_epc  out  32 each  live register values.
- c0_int  out  1  pending enabled interrupt.

Function
REQ-004 SHALL implement these registers: BadVAddr {8,0}, Count {9,0}, Compare {11,0}, Status {12,0}, Cause {13,0}, EPC {14,0}.
REQ-005 SHALL return 0 on cp0r_rdata for any other address.
REQ-006 Status layout SHALL be: bit22 BEV (read-only 1), bits15:8 IM (read/write), bit1 EXL (read/write), bit0 IE (read/write); all other bits read 0.
REQ-007 Cause layout SHALL be: bit31 BD, bit30 TI, bits15:10 IP hardware (IP7 = TI), bits9:8 IP software (read/write), bits6:2 ExcCode; all other bits read 0.
REQ-008 Define commit = wb_over & wb_valid.
REQ-009 An MTC0 write SHALL take effect only when mtc0 & commit & ~ex_valid_i, at the next clock edge.
REQ-010 Exception commit SHALL occur when ex_valid_i & commit:
- ExcCode <= ex_code_i.
- EXL <= 1.
- If EXL was 0: EPC <= ex_bd_i ? ex_pc_i-4 : ex_pc_i, and BD <= ex_bd_i.
- If EXL was 1: EPC and BD are unchanged.
- If badvaddr_valid_i: BadVAddr <= badvaddr_i.
REQ-011 ERET commit (eret & commit & ~ex_valid_i) SHALL clear EXL.
REQ-012 exc_valid SHALL be (ex_valid_i | eret) & commit, combinational.
REQ-013 exc_pc SHALL be EXC_ENTRY when ex_valid_i is set, otherwise EPC (the pre-update value).
REQ-014 cancel SHALL equal exc_valid.
REQ-015 Count SHALL increment by 1 every second clock, using an internal toggle bit reset to 0, and wrap from FFFF_FFFF to 0.
REQ-016 An MTC0 write to Count SHALL override that cycle's increment.
REQ-017 TI SHALL be set when Count == Compare and Compare has been written since reset.
REQ-018 An MTC0 write to Compare SHALL clear TI; the clear wins over a simultaneous set.
REQ-019 c0_int SHALL equal IE & ~EXL & |(Cause[15:8] & IM), combinational.
REQ-020 When an exception commit and an MTC0 write target the same field in one cycle, the exception update SHALL win.
REQ-021 cp0r_rdata SHALL reflect the register value before any same-cycle write.

Reset
REQ-022 On reset assertion (asynchronous), the registers SHALL take these values:
- Status = 32'h0040_0000.
- Cause = 0.
- EPC = 0.
- BadVAddr = 0.
- Count = 0.
- Compare = 0.
- Compare-written flag = 0.
REQ-023 During reset, all derived outputs SHALL be:
- c0_int = 0.
- exc_valid = 0.
- cancel = 0.
- exc_pc = EPC = 0.
- cp0r_rdata = 0 unless the addressed register is Status, which reads 32'h0040_0000.

Verification
REQ-024 Syscall: ex_valid_i=1, ex_code_i=8, ex_bd_i=0, ex_pc_i=32'h0000_1000, wb_valid=wb_over=1 -> exc_valid=1, exc_pc=32'hBFC0_0380, cancel=1; next cycle EPC=32'h1000, Cause[6:2]=8, Status[1]=1.
REQ-025 ERET after REQ-024: eret=1, commit -> exc_valid=1, exc_pc=32'h1000; next cycle Status[1]=0.
REQ-026 AdEL: ex_code_i=4, badvaddr_valid_i=1, badvaddr_i=32'h8000_0003, ex_bd_i=1, ex_pc_i=32'h2004 -> BadVAddr=32'h8000_0003, EPC=32'h2000, Cause[31]=1.
REQ-027 MTC0 Status 32'h0000_8001 then MTC0 Compare 5 -> after Count reaches 5: Cause[30]=1, Cause[15]=1, c0_int=1; MTC0 Compare again -> c0_int=0.
REQ-028 Gated write: MTC0 EPC 32'h1234 with wb_over=0 -> EPC unchanged; mfc0 from address {5'd20,3'd0} -> cp0r_rdata=0.
REQ-029 Async reset asserted mid-operation with EXL=1 -> Status reads 32'h0040_0000 immediately, before the next clock edge.
